carrier_loop_filter: RTL
========================

CARRIER_LOOP_FILTER -- requirements
Module: carrier_loop_filter

Interface
REQ-001 SHALL have parameter ERR_WIDTH, 16, signed phase-error word width.
REQ-002 SHALL have parameter PHASE_WIDTH, 32, frequency-word width (matches NCO freq_word_i).
REQ-003 SHALL have parameter GAIN_SHIFT, 16, arithmetic right shift applied to every gain product.
REQ-004 SHALL have parameter LOCK_COUNT, 8, consecutive in-threshold samples required to declare lock.
REQ-005 SHALL have parameter UNLOCK_COUNT, 4, consecutive out-of-threshold samples required to drop lock.
REQ-006 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port phase_err_i  in  ERR_WIDTH  signed phase error from detector.
REQ-009 SHALL have port phase_err_val_i  in  1  phase_err_i qualifier, one sample per high cycle.
REQ-010 SHALL have port kp_i  in  16  unsigned proportional gain.
REQ-011 SHALL have port ki_i  in  16  unsigned integral gain.
REQ-012 SHALL have port freq_offset_i  in  PHASE_WIDTH  signed nominal frequency word.
REQ-013 SHALL have port lock_thresh_i  in  ERR_WIDTH  unsigned lock magnitude threshold.
REQ-014 SHALL have port hold_i  in  1  freeze integrator.
REQ-015 SHALL have port clear_i  in  1  synchronous clear of integrator, lock state, pipeline.
REQ-016 SHALL have port freq_word_o  out  PHASE_WIDTH  signed frequency word to NCO.
REQ-017 SHALL have port freq_word_val_o  out  1  one-cycle strobe per accepted sample.
REQ-018 SHALL have port lock_o  out  1  loop-locked indicator.

Function
REQ-019 SHALL register stage 1 on phase_err_val_i: prop = (phase_err_i*kp_i) >>> GAIN_SHIFT, inc = (phase_err_i*ki_i) >>> GAIN_SHIFT, gains zero-extended, full-width signed products, floor rounding.
REQ-020 SHALL in stage 2 compute integ_new = sat(integ + inc) to signed PHASE_WIDTH, and register integ <= integ_new unless hold_i is high in that cycle.
REQ-021 SHALL register freq_word_o = sat(freq_offset_i + prop + integ_eff) in stage 2, integ_eff = integ_new (hold_i low) or integ (hold_i high), sum computed at PHASE_WIDTH+2 bits before saturation.
REQ-022 SHALL saturate to 2^(PHASE_WIDTH-1)-1 / -2^(PHASE_WIDTH-1); no wrap-around anywhere.
REQ-023 SHALL assert freq_word_val_o exactly 2 cycles after each phase_err_val_i high cycle, for one cycle; back-to-back inputs give back-to-back strobes.
REQ-024 SHALL hold freq_word_o stable between strobes.
REQ-025 SHALL run lock FSM per stage-2 sample, magnitude |err| computed ERR_WIDTH+1 bits (most-negative value = 2^(ERR_WIDTH-1)), in-threshold = |err| <= lock_thresh_i.
REQ-026 SHALL in UNLOCKED count consecutive in-threshold samples, reset count on out-of-threshold, go LOCKED when count reaches LOCK_COUNT, clearing count.
REQ-027 SHALL in LOCKED count consecutive out-of-threshold samples, reset count on in-threshold, go UNLOCKED when count reaches UNLOCK_COUNT, clearing count.
REQ-028 SHALL update lock_o in the same cycle freq_word_val_o marks the sample causing the transition.
REQ-029 SHALL on clear_i high: zero integ, counters, force UNLOCKED, lock_o=0, drop both pipeline valids; freq_word_o retains value.
REQ-030 SHALL give clear_i priority over simultaneous phase_err_val_i; that sample is discarded, no strobe.
REQ-031 SHALL ignore hold_i for lock FSM and proportional path.

Reset
REQ-032 SHALL on rst high immediately set freq_word_o=0, freq_word_val_o=0, lock_o=0, integ=0, counters=0, state UNLOCKED, pipeline valids=0.
REQ-033 SHALL discard any in-flight sample when rst asserts mid-pipeline; first strobe after release is 2 cycles after first post-reset valid.

Verification
REQ-034 SHALL verify: kp=0x4000, ki=0x0100, freq_offset=0x01000000, two samples err=1000 -> freq_word_o 16777469 then 16777472, strobes 2 cycles after each input.
REQ-035 SHALL verify: err=-1000, ki=0x0100, kp=0, offset=0 -> first output -4 (floor rounding).
REQ-036 SHALL verify: offset=0x7FFFFFF0, kp=0x4000, err=1000 -> freq_word_o=0x7FFFFFFF; err=-32768 with kp=0xFFFF, offset=0x80000000 -> 0x80000000.
REQ-037 SHALL verify: thresh=100, 8 samples err=50 -> lock_o rises with 8th strobe; then 3 samples err=200, 1 of err=0, 4 of err=200 -> lock_o falls with final strobe only.
REQ-038 SHALL verify: hold_i high for 5 samples err=1000, ki=0x0100 -> integ unchanged; clear_i concurrent with valid -> no strobe, integ=0, lock_o=0.
REQ-039 SHALL verify: rst asserted one cycle after valid -> no strobe, all outputs 0 asynchronously.

Source files
------------

// File: rtl/carrier_loop_filter_if.sv
// Sample-stream bundle between phase detector, loop filter and NCO:
// phase-error samples in, frequency words and lock status out.
interface carrier_loop_filter_if #(
  parameter int ERR_WIDTH   = 16,
  parameter int PHASE_WIDTH = 32
);
  logic signed [ERR_WIDTH-1:0]   phase_err_i;
  logic                          phase_err_val_i;
  logic signed [PHASE_WIDTH-1:0] freq_word_o;
  logic                          freq_word_val_o;
  logic                          lock_o;

  modport master (
    output phase_err_i,
    output phase_err_val_i,
    input  freq_word_o,
    input  freq_word_val_o,
    input  lock_o
  );

  modport slave (
    input  phase_err_i,
    input  phase_err_val_i,
    output freq_word_o,
    output freq_word_val_o,
    output lock_o
  );
endinterface

// File: rtl/carrier_loop_filter.sv
// Proportional-integral carrier loop filter with saturating integrator, NCO frequency-word
// output and a hysteretic lock detector; two-cycle latency from sample to strobe.
module carrier_loop_filter #(
  parameter int ERR_WIDTH    = 16,
  parameter int PHASE_WIDTH  = 32,
  parameter int GAIN_SHIFT   = 16,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  carrier_loop_filter_if.slave          loop_if,
  input  logic        [15:0]            kp_i,
  input  logic        [15:0]            ki_i,
  input  logic signed [PHASE_WIDTH-1:0] freq_offset_i,
  input  logic        [ERR_WIDTH-1:0]   lock_thresh_i,
  input  logic                          hold_i,
  input  logic                          clear_i
);

  localparam int PROD_W  = ERR_WIDTH + 17;
  localparam int WIDE_W  = ((PHASE_WIDTH > PROD_W) ? PHASE_WIDTH : PROD_W) + 2;
  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic signed [WIDE_W-1:0] SAT_MAX =
    {{(WIDE_W-PHASE_WIDTH+1){1'b0}}, {(PHASE_WIDTH-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN =
    {{(WIDE_W-PHASE_WIDTH+1){1'b1}}, {(PHASE_WIDTH-1){1'b0}}};

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  function automatic logic signed [PHASE_WIDTH-1:0] sat(input logic signed [WIDE_W-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[PHASE_WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[PHASE_WIDTH-1:0];
    else                  return x[PHASE_WIDTH-1:0];
  endfunction

  // Stage 1: registered gain products; stage 2: integrator, output word and lock FSM.
  logic                          v1_q, v1_d;
  logic signed [ERR_WIDTH-1:0]   err_q, err_d;
  logic signed [PROD_W-1:0]      prop_q, prop_d;
  logic signed [PROD_W-1:0]      inc_q, inc_d;
  logic signed [PHASE_WIDTH-1:0] integ_q, integ_d;
  logic signed [PHASE_WIDTH-1:0] freq_q, freq_d;
  logic                          val_q, val_d;
  logic                          lock_q, lock_d;
  lock_state_e                   state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic signed [PROD_W-1:0]      prop_prod, inc_prod;
  logic signed [PHASE_WIDTH-1:0] integ_new, integ_eff;
  logic signed [WIDE_W-1:0]      freq_sum;
  logic signed [ERR_WIDTH:0]     err_ext;
  logic        [ERR_WIDTH:0]     err_abs;
  logic                          in_thresh;
  logic        [CNT_W-1:0]       cnt_inc;

  always_comb begin
    // Gains are unsigned, so a zero MSB keeps them positive in the signed product.
    prop_prod = loop_if.phase_err_i * $signed({1'b0, kp_i});
    inc_prod  = loop_if.phase_err_i * $signed({1'b0, ki_i});

    integ_new = sat(WIDE_W'(integ_q) + WIDE_W'(inc_q));
    integ_eff = hold_i ? integ_q : integ_new;
    freq_sum  = WIDE_W'(freq_offset_i) + WIDE_W'(prop_q) + WIDE_W'(integ_eff);

    // One extra bit so the most-negative error has a representable magnitude.
    err_ext   = (ERR_WIDTH+1)'(err_q);
    err_abs   = err_ext[ERR_WIDTH] ? -err_ext : err_ext;
    in_thresh = (err_abs <= {1'b0, lock_thresh_i});
    cnt_inc   = cnt_q + CNT_W'(1);
  end

  always_comb begin
    // NOTE: every *_d starts from its *_q, so no path through this block can infer a latch.
    v1_d    = v1_q;
    err_d   = err_q;
    prop_d  = prop_q;
    inc_d   = inc_q;
    integ_d = integ_q;
    freq_d  = freq_q;
    val_d   = val_q;
    lock_d  = lock_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (clear_i) begin
      v1_d    = 1'b0;
      val_d   = 1'b0;
      integ_d = '0;
      cnt_d   = '0;
      state_d = UNLOCKED;
      lock_d  = 1'b0;
    end else begin
      v1_d  = loop_if.phase_err_val_i;
      val_d = v1_q;
      if (loop_if.phase_err_val_i) begin
        err_d  = loop_if.phase_err_i;
        prop_d = prop_prod >>> GAIN_SHIFT;
        inc_d  = inc_prod >>> GAIN_SHIFT;
      end
      if (v1_q) begin
        if (!hold_i) integ_d = integ_new;
        freq_d = sat(freq_sum);
        case (state_q)
          UNLOCKED: begin
            if (!in_thresh) begin
              cnt_d = '0;
            end else if (cnt_inc == CNT_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          LOCKED: begin
            if (in_thresh) begin
              cnt_d = '0;
            end else if (cnt_inc == CNT_W'(UNLOCK_COUNT)) begin
              state_d = UNLOCKED;
              lock_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        endcase
      end
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      err_q   <= '0;
      prop_q  <= '0;
      inc_q   <= '0;
      integ_q <= '0;
      freq_q  <= '0;
      val_q   <= 1'b0;
      lock_q  <= 1'b0;
      state_q <= UNLOCKED;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      err_q   <= err_d;
      prop_q  <= prop_d;
      inc_q   <= inc_d;
      integ_q <= integ_d;
      freq_q  <= freq_d;
      val_q   <= val_d;
      lock_q  <= lock_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign loop_if.freq_word_o     = freq_q;
  assign loop_if.freq_word_val_o = val_q;
  assign loop_if.lock_o          = lock_q;

endmodule
